// File: rtl/iomem_sram_ctrl.sv
// ---------------------------------------------------------------------------
// iomem_sram_ctrl
//
// Memory-side slave for the core's iomem bus. Takes one 128-bit line request
// (valid/ready handshake, 16-bit byte strobe) and turns it into four 32-bit
// beats on a single-port synchronous SRAM. Reads gather the four returning
// words into one line; writes pass the per-byte enables through to the SRAM.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   iomem_valid_i        request valid (sampled only in IDLE)
//   iomem_ready_o        one-cycle completion pulse
//   iomem_wstrb_i        line byte enables, all-zero means read
//   iomem_addr_i         byte address, [3:0] ignored, upper bits wrap
//   iomem_wdata_i        write line, beat k = [32k+31:32k]
//   iomem_rdata_o        read line, valid with ready, held until next read
//   sram_ce_o/we_o/be_o  SRAM chip enable, write enable, byte enables
//   sram_addr_o          SRAM word address = {line index, beat}
//   sram_wdata_o         SRAM write data
//   sram_rdata_i         SRAM read data, RD_LAT cycles after a read beat
//
// Configuration macro
//   IOMEM_RD_BUF_EN      adds a one-line read buffer; a read hitting it
//                        completes in one cycle with no SRAM access.
// ---------------------------------------------------------------------------
module iomem_sram_ctrl #(
    parameter int XLEN      = 32,
    parameter int BLK_SIZE  = 128,
    parameter int MEM_WORDS = 16384,
    parameter int RD_LAT    = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         iomem_valid_i,
    output logic                         iomem_ready_o,
    input  logic [BLK_SIZE/8-1:0]        iomem_wstrb_i,
    input  logic [XLEN-1:0]              iomem_addr_i,
    input  logic [BLK_SIZE-1:0]          iomem_wdata_i,
    output logic [BLK_SIZE-1:0]          iomem_rdata_o,
    output logic                         sram_ce_o,
    output logic                         sram_we_o,
    output logic [3:0]                   sram_be_o,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr_o,
    output logic [31:0]                  sram_wdata_o,
    input  logic [31:0]                  sram_rdata_i
);

    localparam int AW = $clog2(MEM_WORDS);  // SRAM word address width
    localparam int LW = AW - 2;             // line index width

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [1:0]                 r_beat;
    logic [1:0]                 r_drain;
    logic [LW-1:0]              r_line;
    logic [BLK_SIZE/8-1:0]      r_wstrb;
    logic [BLK_SIZE-1:0]        r_wdata;
    logic [95:0]                r_gather;   // words 0..2; word 3 goes straight out
    logic [BLK_SIZE-1:0]        r_rdata;
    logic [RD_LAT-1:0]          r_rd_pipe_vld;
    logic [RD_LAT-1:0][1:0]     r_rd_pipe_idx;

    logic                       w_accept;
    logic                       w_is_read;
    logic                       w_buf_hit;
    logic [LW-1:0]              w_req_line;
    logic [3:0]                 w_nib;
    logic                       w_ret;
    logic [1:0]                 w_ret_idx;
    logic                       w_rd_done;
    logic [BLK_SIZE-1:0]        w_rd_line;
    logic                       w_unused_addr;

    assign w_accept   = (r_state == S_IDLE) && iomem_valid_i;
    assign w_is_read  = (iomem_wstrb_i == '0);
    assign w_req_line = iomem_addr_i[AW+1:4];
    assign w_nib      = r_wstrb[{r_beat, 2'b00} +: 4];

    // Line offset and address bits above the SRAM size are ignored (wrap).
    assign w_unused_addr = ^{iomem_addr_i[XLEN-1:AW+2], iomem_addr_i[3:0]};

    // Read data for a beat returns when its tag leaves the end of the pipe.
    assign w_ret     = r_rd_pipe_vld[RD_LAT-1];
    assign w_ret_idx = r_rd_pipe_idx[RD_LAT-1];
    assign w_rd_done = w_ret && (w_ret_idx == 2'd3);
    assign w_rd_line = {sram_rdata_i, r_gather};

`ifdef IOMEM_RD_BUF_EN
    logic                r_buf_vld;
    logic [LW-1:0]       r_buf_tag;
    logic [BLK_SIZE-1:0] r_buf_data;

    assign w_buf_hit = r_buf_vld && (r_buf_tag == w_req_line);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_buf_vld  <= 1'b0;
            r_buf_tag  <= '0;
            r_buf_data <= '0;
        end else if (w_rd_done) begin
            r_buf_vld  <= 1'b1;
            r_buf_tag  <= r_line;
            r_buf_data <= w_rd_line;
        end else if (w_accept && !w_is_read && w_buf_hit) begin
            // A write to the buffered line makes the copy stale.
            r_buf_vld <= 1'b0;
        end
    end
`else
    assign w_buf_hit = 1'b0;
`endif

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (iomem_valid_i) begin
                    if (!w_is_read)     w_next = S_WRITE;
                    else if (w_buf_hit) w_next = S_RESP;
                    else                w_next = S_READ;
                end
            end
            S_WRITE: if (r_beat == 2'd3) w_next = S_RESP;
            S_READ:  if (r_beat == 2'd3) w_next = S_DRAIN;
            S_DRAIN: if (r_drain == 2'(RD_LAT - 1)) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    // NOTE: every output gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        iomem_ready_o = 1'b0;
        sram_ce_o     = 1'b0;
        sram_we_o     = 1'b0;
        sram_be_o     = 4'h0;
        sram_addr_o   = '0;
        sram_wdata_o  = '0;
        unique case (r_state)
            S_WRITE: begin
                // An all-zero nibble still spends its beat, just without ce.
                sram_ce_o    = (w_nib != 4'h0);
                sram_we_o    = 1'b1;
                sram_be_o    = w_nib;
                sram_addr_o  = {r_line, r_beat};
                sram_wdata_o = r_wdata[{r_beat, 5'b00000} +: 32];
            end
            S_READ: begin
                sram_ce_o   = 1'b1;
                sram_be_o   = 4'hF;
                sram_addr_o = {r_line, r_beat};
            end
            S_RESP:  iomem_ready_o = 1'b1;
            default: ;
        endcase
    end

    assign iomem_rdata_o = r_rdata;

    // Request capture, beat/drain counters and read-return pipeline
    // NOTE: the captured request and gather registers are reset along with
    // control so every output is defined straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_beat        <= 2'd0;
            r_drain       <= 2'd0;
            r_line        <= '0;
            r_wstrb       <= '0;
            r_wdata       <= '0;
            r_gather      <= '0;
            r_rd_pipe_vld <= '0;
            r_rd_pipe_idx <= '0;
        end else begin
            if (w_accept) begin
                r_line  <= w_req_line;
                r_wstrb <= iomem_wstrb_i;
                r_wdata <= iomem_wdata_i;
            end

            if (r_state == S_WRITE || r_state == S_READ) r_beat <= r_beat + 2'd1;
            else                                         r_beat <= 2'd0;

            if (r_state == S_DRAIN) r_drain <= r_drain + 2'd1;
            else                    r_drain <= 2'd0;

            r_rd_pipe_vld[0] <= (r_state == S_READ);
            r_rd_pipe_idx[0] <= r_beat;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_pipe_vld[i] <= r_rd_pipe_vld[i-1];
                r_rd_pipe_idx[i] <= r_rd_pipe_idx[i-1];
            end

            if (w_ret && !w_rd_done) r_gather[{w_ret_idx, 5'b00000} +: 32] <= sram_rdata_i;
        end
    end

    // Read line register: changes only when a read completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if (w_rd_done) begin
            r_rdata <= w_rd_line;
`ifdef IOMEM_RD_BUF_EN
        end else if (w_accept && w_is_read && w_buf_hit) begin
            r_rdata <= r_buf_data;
`endif
        end
    end

endmodule
